// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        CSUM,
        RUN,
        ERR
    } state_e;

    localparam int unsigned HDR_BYTES      = 2;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam logic [7:0]  CSUM_INIT      = 8'h00;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Packs accepted bytes into 32-bit big-endian words; first byte lands in the MSB.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    input  logic        restart_i,
    output logic        last_byte_o,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;
    logic        word_valid_q;
    logic [31:0] word_q;

    // High while the next accepted byte completes a word.
    assign last_byte_o = (cnt_q == 2'(BYTES_PER_WORD - 1));

    // Shift bytes in; publish the word (one-cycle strobe) the cycle after its 4th byte.
    always_ff @(posedge clock) begin
        if (!clear) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
        end else if (restart_i) begin
            // The last word stays visible so the write data holds between loads.
            cnt_q        <= '0;
            shift_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            word_valid_q <= 1'b0;
            if (byte_valid_i) begin
                shift_q <= {shift_q[15:0], byte_i};
                cnt_q   <= cnt_q + 2'd1;
                if (last_byte_o) begin
                    word_q       <= {shift_q, byte_i};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;

endmodule

// File: rtl/program_loader.sv
// Loads a checksummed big-endian program image into instruction memory and
// holds the datapath in clear until a complete, verified image is in place.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_write,
    output logic [31:0] imem_address,
    output logic [31:0] imem_write_data,
    output logic        cpu_clear,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned MaxWords = 1 << ADDR_WIDTH;

    state_e                 state_q;
    logic                   rx_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic                   cpu_clear_q;
    logic                   hdr_cnt_q;
    logic [7:0]             hdr_hi_q;
    logic [COUNT_WIDTH-1:0] word_count_q;
    logic [COUNT_WIDTH-1:0] word_index_q;
    logic [7:0]             csum_q;
    logic [31:0]            imem_address_q;

    logic        accept;
    logic        restart;
    logic        load_accept;
    logic        last_byte;
    logic        last_word;
    logic [15:0] hdr_count;
    logic        hdr_bad;

    assign accept      = rx_valid & rx_ready_q;
    assign restart     = start & ((state_q == IDLE) | (state_q == RUN) | (state_q == ERR));
    assign load_accept = accept & (state_q == LOAD);
    assign hdr_count   = {hdr_hi_q, rx_data};
    assign hdr_bad     = (hdr_count == 16'd0) || (32'(hdr_count) > MaxWords);
    assign last_word   = (word_index_q == word_count_q - COUNT_WIDTH'(1));

    program_loader_byte_assembler u_byte_assembler (
        .clock        (clock),
        .clear        (clear),
        .byte_valid_i (load_accept),
        .byte_i       (rx_data),
        .restart_i    (restart),
        .last_byte_o  (last_byte),
        .word_valid_o (imem_write),
        .word_o       (imem_write_data)
    );

    // Load sequencer; every status output is registered alongside the state.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q        <= IDLE;
            rx_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_clear_q    <= 1'b1;
            hdr_cnt_q      <= 1'b0;
            hdr_hi_q       <= '0;
            word_count_q   <= '0;
            word_index_q   <= '0;
            csum_q         <= CSUM_INIT;
            imem_address_q <= '0;
        end else begin
            unique case (state_q)
                IDLE, RUN, ERR: begin
                    if (start) begin
                        state_q      <= HDR;
                        rx_ready_q   <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        cpu_clear_q  <= 1'b1;
                        hdr_cnt_q    <= 1'b0;
                        word_index_q <= '0;
                        csum_q       <= CSUM_INIT;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (hdr_cnt_q != 1'(HDR_BYTES - 1)) begin
                            hdr_hi_q  <= rx_data;
                            hdr_cnt_q <= 1'b1;
                        end else if (hdr_bad) begin
                            state_q    <= ERR;
                            rx_ready_q <= 1'b0;
                            busy_q     <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            state_q      <= LOAD;
                            word_count_q <= COUNT_WIDTH'(hdr_count);
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        csum_q <= csum_q ^ rx_data;
                        if (last_byte) begin
                            // Latched with the word so address and data stay paired.
                            imem_address_q <= 32'(word_index_q) << 2;
                            word_index_q   <= word_index_q + COUNT_WIDTH'(1);
                            if (last_word) begin
                                state_q <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (rx_data == csum_q) begin
                            state_q     <= RUN;
                            done_q      <= 1'b1;
                            cpu_clear_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    rx_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_address = imem_address_q;
    assign cpu_clear    = cpu_clear_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of whole-image loads plus hand sequences.
module tb_program_loader;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_write;
    logic [31:0] imem_address;
    logic [31:0] imem_write_data;
    logic        cpu_clear;
    logic        busy;
    logic        done;
    logic        error;

    program_loader dut (
        .clock           (clock),
        .clear           (clear),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .imem_write      (imem_write),
        .imem_address    (imem_address),
        .imem_write_data (imem_write_data),
        .cpu_clear       (cpu_clear),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Write monitor: records every strobe seen between rising edges.
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_total = 0;

    always @(negedge clock) begin
        if (imem_write === 1'b1) begin
            if (wr_total < 64) begin
                wr_addr[wr_total] = imem_address;
                wr_data[wr_total] = imem_write_data;
            end
            wr_total = wr_total + 1;
        end
    end

    typedef struct {
        logic [95:0] stream;   // right-aligned, first byte most significant
        int          nb;
        bit          gaps;
        logic        exp_done;
        logic        exp_err;
        int          exp_wr;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge; gap cycles optionally carry stray starts.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit noisy);
        int t;
        rx_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clock);
        end
        start    = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        t        = 0;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (rx_ready !== 1'b1) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic run_load(input vec_t v, input int idx);
        int base;
        base  = wr_total;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check($sformatf("v%0d busy_after_start", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d cpu_clear_after_start", idx), {31'd0, cpu_clear}, 32'd1);
        check($sformatf("v%0d rx_ready_in_hdr", idx), {31'd0, rx_ready}, 32'd1);
        check($sformatf("v%0d done_cleared", idx), {31'd0, done}, 32'd0);
        check($sformatf("v%0d error_cleared", idx), {31'd0, error}, 32'd0);
        for (int i = 0; i < v.nb; i++) begin
            send_byte(v.stream[8*(v.nb-1-i) +: 8], v.gaps ? int'($urandom_range(0, 5)) : 0,
                      v.gaps);
        end
        #1;
        check($sformatf("v%0d done", idx), {31'd0, done}, {31'd0, v.exp_done});
        check($sformatf("v%0d error", idx), {31'd0, error}, {31'd0, v.exp_err});
        check($sformatf("v%0d cpu_clear", idx), {31'd0, cpu_clear}, {31'd0, !v.exp_done});
        check($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd0);
        check($sformatf("v%0d rx_ready", idx), {31'd0, rx_ready}, 32'd0);
        check($sformatf("v%0d writes", idx), wr_total - base, v.exp_wr);
        if (v.exp_wr >= 1) begin
            check($sformatf("v%0d wr0_addr", idx), wr_addr[base], 32'h0);
            check($sformatf("v%0d wr0_data", idx), wr_data[base], v.w0);
        end
        if (v.exp_wr >= 2) begin
            check($sformatf("v%0d wr1_addr", idx), wr_addr[base+1], 32'h4);
            check($sformatf("v%0d wr1_data", idx), wr_data[base+1], v.w1);
            check($sformatf("v%0d addr_hold", idx), imem_address, 32'h4);
            check($sformatf("v%0d data_hold", idx), imem_write_data, v.w1);
            check($sformatf("v%0d write_idle", idx), {31'd0, imem_write}, 32'd0);
        end
    endtask

    initial begin
        // XOR of payload bytes 20 08 00 05 01 09 40 20 is 8'h45.
        vecs[0] = '{96'h0002_2008_0005_0109_4020_45, 11, 1'b0, 1'b1, 1'b0, 2,
                    32'h20080005, 32'h01094020};
        vecs[1] = '{96'h0002_2008_0005_0109_4020_46, 11, 1'b0, 1'b0, 1'b1, 2,
                    32'h20080005, 32'h01094020};
        vecs[2] = vecs[0];
        vecs[3] = '{96'h0000, 2, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[4] = '{96'h0101, 2, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[5] = vecs[0];
        vecs[5].gaps = 1'b1;

        // Reset dominates start and rx traffic.
        clear    = 1'b0;
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'hff;
        repeat (2) @(negedge clock);
        check("rst rx_ready", {31'd0, rx_ready}, 32'd0);
        check("rst imem_write", {31'd0, imem_write}, 32'd0);
        check("rst imem_address", imem_address, 32'd0);
        check("rst imem_write_data", imem_write_data, 32'd0);
        check("rst cpu_clear", {31'd0, cpu_clear}, 32'd1);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst error", {31'd0, error}, 32'd0);
        clear    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        @(negedge clock);
        check("idle rx_ready", {31'd0, rx_ready}, 32'd0);

        for (int i = 0; i < 6; i++) run_load(vecs[i], i);

        // Start in RUN together with rx_valid: that byte must not be consumed.
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        @(negedge clock);
        start    = 1'b0;
        rx_valid = 1'b0;
        check("run_restart cpu_clear", {31'd0, cpu_clear}, 32'd1);
        check("run_restart done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 11; i++) send_byte(vecs[0].stream[8*(10-i) +: 8], 0, 1'b0);
        #1;
        check("run_restart load_done", {31'd0, done}, 32'd1);

        // Reset after 5 payload bytes, then a clean reload.
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(vecs[0].stream[8*(10-i) +: 8], 0, 1'b0);
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        check("midrst rx_ready", {31'd0, rx_ready}, 32'd0);
        check("midrst cpu_clear", {31'd0, cpu_clear}, 32'd1);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst done", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("midrst idle rx_ready", {31'd0, rx_ready}, 32'd0);
        run_load(vecs[0], 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot-time stage directly upstream of the single-cycle datapath's instruction memory. It receives a program image as a byte stream over a valid/ready handshake and packs it into 32-bit big-endian words. Each word is written into the instruction memory's write port. While loading, the block holds the datapath in clear. It releases the datapath only after a complete, checksum-verified image has been written.

Parameters:
ADDR_WIDTH, 8, word-address bits of instruction memory; capacity MAX_WORDS = 2**ADDR_WIDTH
COUNT_WIDTH, 16, width of the word-count header field

Ports:
clock  in  1  system clock; all state changes on rising edge
clear  in  1  synchronous, active-low reset (0 = reset on next rising edge)
start  in  1  one-cycle request to begin a load
rx_data  in  8  incoming image byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte this cycle
imem_write  out  1  one-cycle write strobe to instruction memory
imem_address  out  32  byte address of the write; word-aligned, equals word_index<<2
imem_write_data  out  32  packed instruction word
cpu_clear  out  1  high holds the datapath in clear
busy  out  1  load in progress
done  out  1  verified image loaded; datapath running
error  out  1  last load failed

Behaviour:
- Reset (clear=0 at edge): state IDLE.
  - Output reset values: rx_ready=0, imem_write=0, imem_address=0, imem_write_data=0, cpu_clear=1, busy=0, done=0, error=0.
  - Reset overrides start and rx traffic in the same cycle.
- Byte transfer: a byte transfers only on a cycle with rx_valid=1 and rx_ready=1.
  - rx_ready is a registered decode of state: 1 in HDR, LOAD and CSUM; 0 otherwise.
  - rx_valid may drop between bytes (gaps allowed, any length).
- Image format:
  - 2-byte big-endian word count N.
  - 4*N payload bytes, MSB of each word first.
  - 1 checksum byte equal to the XOR of all payload bytes (header excluded).
- States:
  - IDLE: start=1 -> HDR; clear counters and checksum; busy=1, done=0, error=0, cpu_clear=1.
  - HDR: accepts 2 bytes. After the second byte: if N==0 or N>MAX_WORDS -> ERR, otherwise -> LOAD.
  - LOAD:
    - Each accepted byte shifts into the word assembler and is XORed into the running checksum.
    - On the 4th byte of a word, in the next cycle: imem_write=1 for exactly one cycle, imem_address=word_index<<2, imem_write_data=assembled word. word_index then increments.
    - After word N is accepted -> CSUM. The write of the last word still occurs in the first CSUM cycle.
  - CSUM: accepts 1 byte. If it equals the running checksum -> RUN, otherwise -> ERR.
  - RUN: done=1, busy=0, cpu_clear=0, all from the cycle after the checksum byte is accepted. start=1 -> HDR; cpu_clear=1 again from the next cycle.
  - ERR: error=1, busy=0, cpu_clear=1. start=1 -> HDR, which clears error.
- Start rules: start is ignored in HDR, LOAD and CSUM.
- Write addressing: imem_address never exceeds (MAX_WORDS-1)<<2, so no wrap-around is possible. imem_address and imem_write_data hold their last values when imem_write=0.
- Reset mid-load: returns to IDLE with cpu_clear=1. Words already written are not rolled back; the datapath stays cleared until a full load succeeds.
- Simultaneous events: a start in RUN on the same cycle as rx_valid does not consume that byte, because rx_ready=0 in RUN.

Decomposition:
- Package program_loader_pkg holds:
  - state enum {IDLE, HDR, LOAD, CSUM, RUN, ERR};
  - HDR_BYTES=2 and BYTES_PER_WORD=4;
  - the checksum init constant 8'h00.
- One sub-module: byte_assembler.
  - Behaviour: 4-byte big-endian shift register with a 2-bit byte counter; outputs word_valid and the word.
  - Ports: clock, clear, a byte-accept input, a reset-counter input.

Test Plan:
1. Reset: clear=0 for 2 cycles with start=1 and rx_valid=1 -> all outputs at reset values, cpu_clear=1, no rx_ready.
2. Good load, N=2: bytes 00 02 20 08 00 05 01 09 40 20 45 ->
   - write addr 0x0 data 0x20080005;
   - write addr 0x4 data 0x01094020;
   - done=1 and cpu_clear=0 one cycle after byte 45 is accepted.
3. Bad checksum: same stream ending 46 -> error=1, cpu_clear=1, done=0. start, then the correct stream -> done=1.
4. Bad header:
   - 00 00 -> ERR right after the second byte, with no imem_write;
   - 01 01 with ADDR_WIDTH=8 -> ERR.
5. Backpressure: stream from scenario 2 with random 0-5 cycle rx_valid gaps, plus start pulses during LOAD -> identical writes and result; start ignored.
6. Reset mid-load after 5 payload bytes -> IDLE, rx_ready=0, cpu_clear=1. A new start plus the full scenario 2 stream -> done=1, with the 2 correct writes.
